// File: rtl/gp_rw_arbiter.sv
// gp_rw_arbiter: serialises the GP read and write channels of the AXI-lite
// slave onto a single shared register/peripheral bus. Ties are resolved
// round-robin. A per-access timeout turns a missing bus_ack into an error
// response, so the AXI side always gets an answer.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | no access in flight; sample requests, arbitrate, latch bus regs
// BUSY  | bus_req high, waiting for bus_ack or the timeout terminal count
// RESP  | one-cycle done/error pulse to the granted channel
module gp_rw_arbiter #(
  parameter int GP_ADDR_WIDTH = 6,
  parameter int DATA_WIDTH    = 32,
  parameter int TIMEOUT       = 16
) (
  input  logic                      s_axi_aclk,
  input  logic                      rst,
  input  logic                      write,
  input  logic [GP_ADDR_WIDTH-1:0]  write_addrs,
  input  logic [DATA_WIDTH-1:0]     write_data,
  input  logic [DATA_WIDTH/8-1:0]   write_strobe,
  output logic                      write_done,
  output logic                      write_error,
  input  logic                      read,
  input  logic [GP_ADDR_WIDTH-1:0]  read_addrs,
  output logic [DATA_WIDTH-1:0]     read_data,
  output logic                      read_done,
  output logic                      read_error,
  output logic                      bus_req,
  output logic                      bus_we,
  output logic [GP_ADDR_WIDTH-1:0]  bus_addr,
  output logic [DATA_WIDTH-1:0]     bus_wdata,
  output logic [DATA_WIDTH/8-1:0]   bus_strb,
  input  logic [DATA_WIDTH-1:0]     bus_rdata,
  input  logic                      bus_ack,
  input  logic                      bus_err
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  // Wide enough to hold TIMEOUT-1; a TIMEOUT of 1 still needs one bit.
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          last_grant_w;  // 1 = last grant went to write, 0 = read
  logic          cur_w;         // channel owning the access in flight
  logic          resp_err;
  logic          grant_any, grant_w, ack_now, tmo_now;

  // State register.
  always_ff @(posedge s_axi_aclk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state, arbitration and BUSY termination decode. An ack in the
  // terminal-count cycle takes priority over the timeout.
  always_comb begin
    state_nxt = state;
    grant_any = 1'b0;
    grant_w   = 1'b0;
    ack_now   = 1'b0;
    tmo_now   = 1'b0;
    case (state)
      IDLE: begin
        if (write || read) begin
          grant_any = 1'b1;
          grant_w   = write && (!read || !last_grant_w);
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (bus_ack) begin
          ack_now   = 1'b1;
          state_nxt = RESP;
        end else if (cnt == CNT_LAST) begin
          tmo_now   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: bus register latch on grant, timeout counter, response capture.
  always_ff @(posedge s_axi_aclk) begin
    if (rst) begin
      bus_we       <= 1'b0;
      bus_addr     <= '0;
      bus_wdata    <= '0;
      bus_strb     <= '0;
      cnt          <= '0;
      last_grant_w <= 1'b0;
      cur_w        <= 1'b0;
      resp_err     <= 1'b0;
      read_data    <= '0;
    end else begin
      if (grant_any) begin
        cur_w        <= grant_w;
        last_grant_w <= grant_w;
        bus_we       <= grant_w;
        bus_addr     <= grant_w ? write_addrs  : read_addrs;
        bus_wdata    <= grant_w ? write_data   : '0;
        bus_strb     <= grant_w ? write_strobe : '0;
        cnt          <= '0;
      end
      if (state == BUSY && !ack_now && !tmo_now) cnt <= cnt + 1'b1;
      if (ack_now) begin
        resp_err <= bus_err;
        if (!cur_w) read_data <= bus_rdata;
      end
      if (tmo_now) begin
        resp_err <= 1'b1;
        if (!cur_w) read_data <= '0;
      end
    end
  end

  assign bus_req     = (state == BUSY);
  assign write_done  = (state == RESP) && cur_w;
  assign read_done   = (state == RESP) && !cur_w;
  assign write_error = write_done && resp_err;
  assign read_error  = read_done && resp_err;

endmodule

// File: tb/tb_gp_rw_arbiter.sv
// Directed bench for gp_rw_arbiter: tie arbitration, single write, delayed
// ack, timeout, bus error, ack on terminal count and mid-access reset.
module tb_gp_rw_arbiter;

  localparam int AW = 6;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          s_axi_aclk = 1'b0;
  logic          rst = 1'b1;
  logic          write = 1'b0;
  logic [AW-1:0] write_addrs = '0;
  logic [DW-1:0] write_data = '0;
  logic [DW/8-1:0] write_strobe = '0;
  logic          write_done, write_error;
  logic          read = 1'b0;
  logic [AW-1:0] read_addrs = '0;
  logic [DW-1:0] read_data;
  logic          read_done, read_error;
  logic          bus_req, bus_we;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic [DW/8-1:0] bus_strb;
  logic [DW-1:0] bus_rdata = '0;
  logic          bus_ack = 1'b0;
  logic          bus_err = 1'b0;

  int checks = 0;
  int failures = 0;
  int n;

  gp_rw_arbiter #(.GP_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .s_axi_aclk(s_axi_aclk), .rst(rst),
    .write(write), .write_addrs(write_addrs), .write_data(write_data),
    .write_strobe(write_strobe), .write_done(write_done), .write_error(write_error),
    .read(read), .read_addrs(read_addrs), .read_data(read_data),
    .read_done(read_done), .read_error(read_error),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_strb(bus_strb), .bus_rdata(bus_rdata),
    .bus_ack(bus_ack), .bus_err(bus_err)
  );

  always #5 s_axi_aclk = ~s_axi_aclk;

  // One clock: inputs change and outputs are sampled at the falling edge.
  task automatic tick();
    @(posedge s_axi_aclk);
    @(negedge s_axi_aclk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    @(negedge s_axi_aclk);
    tick();
    // Reset values
    chk("rst_bus_req", bus_req, 0);
    chk("rst_bus_we", bus_we, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_bus_wdata", bus_wdata, 0);
    chk("rst_bus_strb", bus_strb, 0);
    chk("rst_wdone", write_done, 0);
    chk("rst_werr", write_error, 0);
    chk("rst_rdone", read_done, 0);
    chk("rst_rerr", read_error, 0);
    chk("rst_rdata", read_data, 0);
    rst = 1'b0;
    tick();

    // Tie after reset: write first, then read
    write = 1; write_addrs = 6'h22; write_data = 32'hCAFE0022; write_strobe = 4'hC;
    read = 1; read_addrs = 6'h11;
    tick();
    chk("tie1_req", bus_req, 1);
    chk("tie1_we", bus_we, 1);
    chk("tie1_addr", bus_addr, 6'h22);
    chk("tie1_wdata", bus_wdata, 32'hCAFE0022);
    chk("tie1_strb", bus_strb, 4'hC);
    bus_ack = 1;
    tick();
    chk("tie1_wdone", write_done, 1);
    chk("tie1_rdone_lo", read_done, 0);
    chk("tie1_req_lo", bus_req, 0);
    bus_ack = 0; write = 0;
    tick();
    chk("tie1_idle_req", bus_req, 0);
    tick();
    chk("tie2_req", bus_req, 1);
    chk("tie2_we", bus_we, 0);
    chk("tie2_addr", bus_addr, 6'h11);
    bus_ack = 1; bus_rdata = 32'hBABA1195;
    tick();
    chk("tie2_rdone", read_done, 1);
    chk("tie2_rerr", read_error, 0);
    chk("tie2_rdata", read_data, 32'hBABA1195);
    chk("tie2_wdone_lo", write_done, 0);
    bus_ack = 0; bus_rdata = '0; read = 0;
    tick();

    // Single write, ack on first BUSY cycle
    write = 1; write_addrs = 6'h04; write_data = 32'h12345678; write_strobe = 4'hF;
    tick();
    chk("wr_req", bus_req, 1);
    chk("wr_we", bus_we, 1);
    chk("wr_addr", bus_addr, 6'h04);
    chk("wr_wdata", bus_wdata, 32'h12345678);
    chk("wr_strb", bus_strb, 4'hF);
    chk("wr_done_early", write_done, 0);
    bus_ack = 1;
    tick();
    chk("wr_done", write_done, 1);
    chk("wr_err", write_error, 0);
    bus_ack = 0; write = 0;
    tick();
    chk("wr_done_pulse", write_done, 0);

    // Tie with last grant = write: read goes first
    write = 1; write_addrs = 6'h05; write_data = 32'h0000_0505; write_strobe = 4'h1;
    read = 1; read_addrs = 6'h06;
    tick();
    chk("tie3_we", bus_we, 0);
    chk("tie3_addr", bus_addr, 6'h06);
    bus_ack = 1; bus_rdata = 32'h0606_0606;
    tick();
    chk("tie3_rdone", read_done, 1);
    chk("tie3_rdata", read_data, 32'h0606_0606);
    bus_ack = 0; read = 0;
    tick();
    tick();
    chk("tie4_we", bus_we, 1);
    chk("tie4_addr", bus_addr, 6'h05);
    bus_ack = 1;
    tick();
    chk("tie4_wdone", write_done, 1);
    bus_ack = 0; write = 0;
    tick();

    // Ack outside BUSY is ignored
    bus_ack = 1;
    tick();
    chk("stray_ack_req", bus_req, 0);
    chk("stray_ack_rdone", read_done, 0);
    bus_ack = 0;

    // Read with ack delayed 3 cycles
    read = 1; read_addrs = 6'h2A;
    tick();
    n = 0;
    for (int i = 0; i < 3; i++) begin
      if (bus_req === 1'b1) n++;
      chk("dly_addr", bus_addr, 6'h2A);
      chk("dly_rdone_early", read_done, 0);
      tick();
    end
    if (bus_req === 1'b1) n++;
    bus_ack = 1; bus_rdata = 32'hDEADBEEF;
    tick();
    chk("dly_req_cycles", n, 4);
    chk("dly_rdone", read_done, 1);
    chk("dly_rdata", read_data, 32'hDEADBEEF);
    chk("dly_rerr", read_error, 0);
    bus_ack = 0; bus_rdata = '0; read = 0;
    tick();
    chk("dly_rdone_pulse", read_done, 0);
    chk("dly_rdata_hold", read_data, 32'hDEADBEEF);

    // Timeout, no ack
    read = 1; read_addrs = 6'h3F;
    tick();
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus_req === 1'b1) n++;
      if (read_done === 1'b1) break;
      tick();
    end
    chk("tmo_req_cycles", n, TO);
    chk("tmo_rdone", read_done, 1);
    chk("tmo_rerr", read_error, 1);
    chk("tmo_rdata", read_data, 0);
    read = 0;
    tick();
    chk("tmo_rerr_pulse", read_error, 0);

    // Write with bus_err
    write = 1; write_addrs = 6'h10; write_data = 32'h1; write_strobe = 4'h1;
    tick();
    bus_ack = 1; bus_err = 1;
    tick();
    chk("berr_wdone", write_done, 1);
    chk("berr_werr", write_error, 1);
    chk("berr_rdone_lo", read_done, 0);
    bus_ack = 0; bus_err = 0; write = 0;
    tick();

    // Ack in the terminal-count cycle wins over the timeout
    read = 1; read_addrs = 6'h01;
    tick();
    for (int i = 0; i < TO - 1; i++) tick();
    chk("tc_req", bus_req, 1);
    bus_ack = 1; bus_rdata = 32'h5A5A_A5A5;
    tick();
    chk("tc_rdone", read_done, 1);
    chk("tc_rerr", read_error, 0);
    chk("tc_rdata", read_data, 32'h5A5A_A5A5);
    bus_ack = 0; bus_rdata = '0; read = 0;
    tick();

    // Reset during BUSY aborts the access
    write = 1; write_addrs = 6'h2B; write_data = 32'hFFFF_0000; write_strobe = 4'h3;
    tick();
    chk("rstb_req_before", bus_req, 1);
    rst = 1; write = 0;
    tick();
    chk("rstb_req", bus_req, 0);
    chk("rstb_we", bus_we, 0);
    chk("rstb_addr", bus_addr, 0);
    chk("rstb_wdata", bus_wdata, 0);
    chk("rstb_strb", bus_strb, 0);
    chk("rstb_wdone", write_done, 0);
    chk("rstb_rdata", read_data, 0);
    rst = 0;
    tick();
    chk("rstb_no_done", write_done, 0);
    write = 1; write_addrs = 6'h08; write_data = 32'h0000_00A5; write_strobe = 4'h1;
    tick();
    chk("post_req", bus_req, 1);
    chk("post_addr", bus_addr, 6'h08);
    bus_ack = 1;
    tick();
    chk("post_wdone", write_done, 1);
    chk("post_werr", write_error, 0);
    bus_ack = 0; write = 0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
